// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_scheduler
//  Description : Latches floor-call buttons, runs the car-motion state
//                machine and produces the sim_state / destination values
//                rendered by the VGA controller. Motion and door timing
//                advance on the divided tick enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_scheduler #(
   parameter int FLOORS     = 8,
   parameter int MOVE_TICKS = 4,
   parameter int DOOR_TICKS = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [FLOORS-1:0] call_btn,
   output logic [FLOORS-1:0] destination,
   output logic [1:0]        sim_state,
   output logic [2:0]        current_floor,
   output logic              door_open
);

   // Counter sized for the longer of the two timed intervals.
   localparam int c_MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
   localparam int c_CNT_W     = $clog2(c_MAX_TICKS + 1);

   localparam logic [c_CNT_W-1:0] c_MOVE_LAST = c_CNT_W'(MOVE_TICKS - 1);
   localparam logic [c_CNT_W-1:0] c_DOOR_LAST = c_CNT_W'(DOOR_TICKS - 1);
   localparam logic [2:0]         c_TOP_FLOOR = 3'(FLOORS - 1);

   // Encoding matches the sim_state values the display path decodes.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10,
      ST_DOOR = 2'b11
   } state_t;

   state_t               r_state;
   logic [FLOORS-1:0]    r_pend;
   logic [2:0]           r_floor;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_dir_up;

   state_t               w_state_nxt;
   logic [2:0]           w_floor_nxt;
   logic [c_CNT_W-1:0]   w_cnt_nxt;
   logic                 w_dir_nxt;
   logic [FLOORS-1:0]    w_clear;
   logic [2:0]           w_step;
   logic                 w_here;
   logic                 w_above;
   logic                 w_below;

   // Any request strictly above the given floor.
   function automatic logic f_above(input logic [FLOORS-1:0] mask,
                                    input logic [2:0]        floor);
      logic r;
      r = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (i > int'(floor)) r = r | mask[i];
      end
      return r;
   endfunction

   // Any request strictly below the given floor.
   function automatic logic f_below(input logic [FLOORS-1:0] mask,
                                    input logic [2:0]        floor);
      logic r;
      r = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (i < int'(floor)) r = r | mask[i];
      end
      return r;
   endfunction

   // Request bit at the given floor; loop form keeps the index in range
   // for any legal FLOORS.
   function automatic logic f_at(input logic [FLOORS-1:0] mask,
                                 input logic [2:0]        floor);
      logic r;
      r = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (i == int'(floor)) r = mask[i];
      end
      return r;
   endfunction

   // One-hot mask selecting the given floor.
   function automatic logic [FLOORS-1:0] f_onehot(input logic [2:0] floor);
      logic [FLOORS-1:0] r;
      r = '0;
      for (int i = 0; i < FLOORS; i++) begin
         r[i] = (i == int'(floor));
      end
      return r;
   endfunction

   // Request summary relative to the floor the car currently occupies.
   always_comb begin
      w_here  = f_at(r_pend, r_floor);
      w_above = f_above(r_pend, r_floor);
      w_below = f_below(r_pend, r_floor);
   end

   // Next-state, motion and request-clear decode.
   always_comb begin
      w_state_nxt = r_state;
      w_floor_nxt = r_floor;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir_up;
      w_clear     = '0;
      w_step      = r_floor;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_here) begin
               w_state_nxt = ST_DOOR;
               w_clear     = f_onehot(r_floor);
            end else if (w_above && w_below) begin
               // Requests on both sides: keep going the way we last went.
               w_state_nxt = r_dir_up ? ST_UP : ST_DOWN;
            end else if (w_above) begin
               w_state_nxt = ST_UP;
               w_dir_nxt   = 1'b1;
            end else if (w_below) begin
               w_state_nxt = ST_DOWN;
               w_dir_nxt   = 1'b0;
            end
         end

         ST_UP, ST_DOWN: begin
            if (tick) begin
               if (r_cnt == c_MOVE_LAST) begin
                  w_cnt_nxt = '0;
                  // Saturating step; a move only starts with a request
                  // ahead, so the limits act purely as a guard.
                  if (r_state == ST_UP) begin
                     if (r_floor != c_TOP_FLOOR) w_step = r_floor + 3'd1;
                  end else begin
                     if (r_floor != 3'd0) w_step = r_floor - 3'd1;
                  end
                  w_floor_nxt = w_step;
                  // Arrival decision uses only requests latched before
                  // this edge.
                  if (f_at(r_pend, w_step)) begin
                     w_state_nxt = ST_DOOR;
                     w_clear     = f_onehot(w_step);
                  end else if ((r_state == ST_UP)   && f_above(r_pend, w_step)) begin
                     w_state_nxt = ST_UP;
                  end else if ((r_state == ST_DOWN) && f_below(r_pend, w_step)) begin
                     w_state_nxt = ST_DOWN;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end

         ST_DOOR: begin
            if (w_here) begin
               // A fresh call at this floor holds the door: restart the
               // dwell and consume the request again.
               w_cnt_nxt = '0;
               w_clear   = f_onehot(r_floor);
            end else if (tick) begin
               if (r_cnt == c_DOOR_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
      endcase
   end

   // State, position, timing and pending-request registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_pend   <= '0;
         r_floor  <= 3'd0;
         r_cnt    <= '0;
         r_dir_up <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_pend   <= (r_pend | call_btn) & ~w_clear;
         r_floor  <= w_floor_nxt;
         r_cnt    <= w_cnt_nxt;
         r_dir_up <= w_dir_nxt;
      end
   end

   assign destination   = r_pend;
   assign sim_state     = r_state;
   assign current_floor = r_floor;
   assign door_open     = (r_state == ST_DOOR);

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_scheduler
//  Description : Self-checking bench for elevator_scheduler. A vector table
//                drives calls and ticks and checks the outputs; a queue of
//                expected door-open floors is matched as the car arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       tick     = 1'b0;
   logic [7:0] call_btn = 8'h00;
   logic [7:0] destination;
   logic [1:0] sim_state;
   logic [2:0] current_floor;
   logic       door_open;

   elevator_scheduler #(
      .FLOORS     (8),
      .MOVE_TICKS (4),
      .DOOR_TICKS (6)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .call_btn      (call_btn),
      .destination   (destination),
      .sim_state     (sim_state),
      .current_floor (current_floor),
      .door_open     (door_open)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] btn;     // one-cycle call pulse (0 = none)
      int         idle;    // plain clocks after the pulse
      int         ticks;   // tick pulses after that
      logic [1:0] st;      // expected sim_state
      logic [2:0] fl;      // expected current_floor
      logic [7:0] dest;    // expected destination
      int         door_a;  // floor expected to open next (-1 none)
      int         door_b;
   } vec_t;

   vec_t vecs[25];
   int   exp_door_q[$];
   int   errors = 0;
   int   checks = 0;
   logic mon_en = 1'b0;
   logic [1:0] prev_state = 2'b00;
   int   mon_f;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
   endtask

   task automatic press(input logic [7:0] mask);
      @(negedge clk) call_btn = mask;
      @(negedge clk) call_btn = 8'h00;
   endtask

   task automatic check_outs(input string tag, input logic [1:0] st, input logic [2:0] fl,
                             input logic [7:0] dest);
      chk({tag, "_state"}, 32'(sim_state),     32'(st));
      chk({tag, "_floor"}, 32'(current_floor), 32'(fl));
      chk({tag, "_dest"},  32'(destination),   32'(dest));
      chk({tag, "_door"},  32'(door_open),     32'(st == 2'b11));
   endtask

   // Door-entry monitor: each arrival must match the next expected floor
   // and that floor's request must already be consumed.
   always @(negedge clk) begin
      if (mon_en && sim_state == 2'b11 && prev_state != 2'b11) begin
         checks++;
         if (exp_door_q.size() == 0) begin
            errors++;
            $display("FAIL door_event: door opened at floor %0d, none expected", current_floor);
         end else begin
            mon_f = exp_door_q.pop_front();
            if (current_floor !== 3'(mon_f) || destination[current_floor] !== 1'b0) begin
               errors++;
               $display("FAIL door_event: floor %0d dest %0h, expected floor %0d with bit clear",
                        current_floor, destination, mon_f);
            end
         end
      end
      prev_state = sim_state;
   end

   // Bound the whole run.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //            btn   idle ticks st     fl    dest   door_a door_b
      vecs[0]  = '{8'h08, 0, 0,  2'b00, 3'd0, 8'h08, 3, -1};
      vecs[1]  = '{8'h00, 1, 0,  2'b01, 3'd0, 8'h08, -1, -1};
      vecs[2]  = '{8'h00, 0, 11, 2'b01, 3'd2, 8'h08, -1, -1};
      vecs[3]  = '{8'h00, 0, 1,  2'b11, 3'd3, 8'h00, -1, -1};
      vecs[4]  = '{8'h00, 0, 5,  2'b11, 3'd3, 8'h00, -1, -1};
      vecs[5]  = '{8'h00, 0, 1,  2'b00, 3'd3, 8'h00, -1, -1};
      vecs[6]  = '{8'h08, 0, 0,  2'b00, 3'd3, 8'h08, 3, -1};
      vecs[7]  = '{8'h00, 1, 0,  2'b11, 3'd3, 8'h00, -1, -1};
      vecs[8]  = '{8'h00, 0, 6,  2'b00, 3'd3, 8'h00, -1, -1};
      vecs[9]  = '{8'h10, 1, 0,  2'b01, 3'd3, 8'h10, 4, -1};
      vecs[10] = '{8'h00, 0, 4,  2'b11, 3'd4, 8'h00, -1, -1};
      vecs[11] = '{8'h42, 0, 0,  2'b11, 3'd4, 8'h42, 6, 1};
      vecs[12] = '{8'h00, 0, 6,  2'b00, 3'd4, 8'h42, -1, -1};
      vecs[13] = '{8'h00, 1, 0,  2'b01, 3'd4, 8'h42, -1, -1};
      vecs[14] = '{8'h00, 0, 8,  2'b11, 3'd6, 8'h02, -1, -1};
      vecs[15] = '{8'h00, 0, 6,  2'b00, 3'd6, 8'h02, -1, -1};
      vecs[16] = '{8'h00, 1, 0,  2'b10, 3'd6, 8'h02, -1, -1};
      vecs[17] = '{8'h00, 0, 20, 2'b11, 3'd1, 8'h00, -1, -1};
      vecs[18] = '{8'h00, 0, 6,  2'b00, 3'd1, 8'h00, -1, -1};
      vecs[19] = '{8'h81, 1, 0,  2'b10, 3'd1, 8'h81, 0, 7};
      vecs[20] = '{8'h00, 0, 4,  2'b11, 3'd0, 8'h80, -1, -1};
      vecs[21] = '{8'h00, 0, 6,  2'b00, 3'd0, 8'h80, -1, -1};
      vecs[22] = '{8'h00, 1, 0,  2'b01, 3'd0, 8'h80, -1, -1};
      vecs[23] = '{8'h00, 0, 28, 2'b11, 3'd7, 8'h00, -1, -1};
      vecs[24] = '{8'h00, 0, 6,  2'b00, 3'd7, 8'h00, -1, -1};

      // Reset held for three clocks, then idle with no calls.
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_outs("reset", 2'b00, 3'd0, 8'h00);
      @(negedge clk) rst = 1'b1;
      repeat (6) @(negedge clk);
      check_outs("idle_hold", 2'b00, 3'd0, 8'h00);
      mon_en = 1'b1;

      // Table-driven scheduling sequence.
      for (int i = 0; i < 25; i++) begin
         if (vecs[i].door_a >= 0) exp_door_q.push_back(vecs[i].door_a);
         if (vecs[i].door_b >= 0) exp_door_q.push_back(vecs[i].door_b);
         if (vecs[i].btn != 8'h00) press(vecs[i].btn);
         repeat (vecs[i].idle) @(negedge clk);
         repeat (vecs[i].ticks) do_tick();
         check_outs($sformatf("row%0d", i), vecs[i].st, vecs[i].fl, vecs[i].dest);
      end

      // Door hold at floor 2: a call after the 5th dwell tick restarts it.
      exp_door_q.push_back(2);
      press(8'h04);
      @(negedge clk);
      check_outs("hold_depart", 2'b10, 3'd7, 8'h04);
      repeat (20) do_tick();
      check_outs("hold_arrive", 2'b11, 3'd2, 8'h00);
      repeat (5) do_tick();
      press(8'h04);
      check_outs("hold_latched", 2'b11, 3'd2, 8'h04);
      @(negedge clk);
      check_outs("hold_recleared", 2'b11, 3'd2, 8'h00);
      repeat (5) do_tick();
      check_outs("hold_still_open", 2'b11, 3'd2, 8'h00);
      do_tick();
      check_outs("hold_closed", 2'b00, 3'd2, 8'h00);

      // Asynchronous reset between floors while travelling down.
      press(8'h01);
      @(negedge clk);
      repeat (2) do_tick();
      check_outs("pre_reset", 2'b10, 3'd2, 8'h01);
      #2 rst = 1'b0;
      #1 check_outs("async_reset", 2'b00, 3'd0, 8'h00);
      @(negedge clk) rst = 1'b1;
      repeat (4) @(negedge clk);
      check_outs("post_reset", 2'b00, 3'd0, 8'h00);

      chk("door_queue_drained", 32'(exp_door_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Request-side counterpart to the VGA display path: latches floor-call buttons, runs the car-motion state machine, and produces the `sim_state` and `destination` values the VGA controller renders.
- Replaces the free-running counter stimulus with real scheduling.
- Single clock domain on the pixel-derived system clock; motion and door timing advance on a divided `tick` enable.

Parameters:
- FLOORS, 8, number of floors; sets width of `call_btn` and `destination`. Legal range 2..8.
- MOVE_TICKS, 4, `tick` pulses to travel one floor.
- DOOR_TICKS, 6, `tick` pulses the door stays open.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tick  input  1  single-cycle timebase enable from the clock divider
- call_btn  input  FLOORS  floor-call buttons, one bit per floor; level-sensitive, sampled every clk
- destination  output  FLOORS  pending-request mask; bit i set = floor i requested and not yet served
- sim_state  output  2  00 IDLE, 01 UP, 10 DOWN, 11 DOOR
- current_floor  output  3  floor the car is at or last passed
- door_open  output  1  high exactly while `sim_state` is DOOR

Behaviour:
- Reset (rst=0, async):
  - destination=0, sim_state=IDLE, current_floor=0, door_open=0.
  - Internal tick counter=0, direction memory=UP.
  - Mid-operation reset abandons motion and door immediately.
- Request latch:
  - Each clk, `pend <= (pend | call_btn) & ~clear`.
  - `clear` is the one-hot of current_floor, asserted only in the cycle the car enters DOOR.
  - A button held through that cycle re-sets the bit on the next cycle.
  - `destination` = `pend` (registered, one-cycle latency from `call_btn`).
- Derived signals, combinational from `pend` and current_floor:
  - `above` = any bit set above current_floor.
  - `below` = any bit set below current_floor.
  - `here` = bit at current_floor.
- IDLE:
  - `here` -> DOOR.
  - Else `above` and `below` both set -> go in the remembered direction.
  - Else `above` -> UP.
  - Else `below` -> DOWN.
  - Transition happens on the clk edge where the condition holds; no tick required.
  - Tick counter cleared on entry to any state.
- UP / DOWN:
  - Count ticks.
  - On the MOVE_TICKS-th tick: current_floor += 1 (UP) or -= 1 (DOWN), counter cleared.
  - Then evaluate against the new floor:
    - `here` -> DOOR.
    - Else a request remains ahead -> stay.
    - Else -> IDLE.
  - Direction memory updated on entering UP/DOWN.
  - current_floor saturates: never above FLOORS-1, never below 0. A move is never started without a request ahead.
- DOOR:
  - door_open=1.
  - On entry, clear the `here` bit (the `clear` cycle).
  - New presses at current_floor while in DOOR restart the counter and re-clear the bit (door hold).
  - On the DOOR_TICKS-th tick -> IDLE; IDLE re-dispatches next cycle.
- Simultaneous events:
  - A tick and a button press in the same cycle are both honoured.
  - A request arriving for a floor the car is passing mid-travel is served only if it is latched before that floor's arrival edge.
- All outputs registered except `door_open`, which is decoded from the state register.

Test Plan:
1. Reset then idle: rst low 3 cycles, no buttons -> destination=0, sim_state=00, current_floor=0, door_open=0 held indefinitely.
2. Single call up: pulse call_btn=8'b0000_1000 one clk -> destination=0x08 next cycle; sim_state=01; current_floor reaches 3 after 12 ticks; DOOR entered with destination=0x00; IDLE after 6 further ticks.
3. Call at current floor: car at 0, press bit0 -> DOOR next cycle, destination bit0 cleared, door_open=1 for 6 ticks.
4. Direction priority: car at 4 moving UP, pend=bit6|bit1 -> serves 6 first (DOOR at 6), then DOWN to 1; current_floor never exceeds 6.
5. Door hold: in DOOR at floor 2, press bit2 at tick 5 -> counter restarts; door_open stays high 6 more ticks.
6. Reset mid-travel: assert rst while sim_state=10 between floors -> all outputs return to reset values within the same cycle (async); pending requests lost.
